// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared types and constants for the song reader
//
// Purpose: FSM state encoding, default widths and the end-of-song marker
// used by song_reader and song_rom.
package music_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    END   = 3'd4
  } state_e;

  localparam int unsigned DEF_IDX_WIDTH  = 5;
  localparam int unsigned DEF_NOTE_WIDTH = 6;
  localparam int unsigned DEF_DUR_WIDTH  = 6;
  localparam int unsigned DEF_SKIP       = 4;

  // Song select forms the upper ROM address bits.
  localparam int unsigned SONG_WIDTH = 2;

  // A ROM word whose duration field equals this value ends the song.
  localparam int unsigned END_OF_SONG_DUR = 0;

endpackage

// File: rtl/song_rom.sv
// rtl/song_rom.sv - synchronous-read note ROM
//
// Purpose: holds {note, duration} words for all songs, one-cycle read latency.
// The image arrives through INIT, which the build generates from the song
// file; word a occupies INIT[a*DATA_WIDTH +: DATA_WIDTH].
// Ports:
//   clk    - clock
//   addr_i - read address {song, idx}
//   data_o - registered read data {note, duration}
module song_rom
  import music_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = SONG_WIDTH + DEF_IDX_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_NOTE_WIDTH + DEF_DUR_WIDTH,
  parameter logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] INIT = '0
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rom [DEPTH];
  logic [DATA_WIDTH-1:0] data_q;

  for (genvar a = 0; a < DEPTH; a++) begin : g_word
    assign rom[a] = INIT[a*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk) begin
    data_q <= rom[addr_i];
  end

  assign data_o = data_q;

endmodule

// File: rtl/song_reader.sv
// rtl/song_reader.sv - fetches notes of the selected song for the note player
//
// Purpose: walks the note index of the current song, reads each ROM word and
// hands it to the note player, honours rewind/ff skips and reports song end.
// Ports:
//   clk          - clock
//   reset        - synchronous active-high reset
//   play         - level, playback enabled
//   rewind       - pulse, step back SKIP notes (saturating at 0)
//   ff           - pulse, step forward SKIP notes (past the end -> song end)
//   reset_player - pulse, restart at note 0
//   song         - selected song, upper ROM address bits
//   note_done    - pulse from note player, current note finished
//   new_note     - pulse, note/duration valid
//   note         - registered note code
//   duration     - registered duration
//   song_done    - pulse, end of song reached
module song_reader
  import music_pkg::*;
#(
  parameter int unsigned IDX_WIDTH  = DEF_IDX_WIDTH,
  parameter int unsigned NOTE_WIDTH = DEF_NOTE_WIDTH,
  parameter int unsigned DUR_WIDTH  = DEF_DUR_WIDTH,
  parameter int unsigned SKIP       = DEF_SKIP,
  parameter logic [(2**(SONG_WIDTH+IDX_WIDTH))*(NOTE_WIDTH+DUR_WIDTH)-1:0] ROM_INIT = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play,
  input  logic                  rewind,
  input  logic                  ff,
  input  logic                  reset_player,
  input  logic [SONG_WIDTH-1:0] song,
  input  logic                  note_done,
  output logic                  new_note,
  output logic [NOTE_WIDTH-1:0] note,
  output logic [DUR_WIDTH-1:0]  duration,
  output logic                  song_done
);

  localparam int unsigned WORD_WIDTH = NOTE_WIDTH + DUR_WIDTH;
  localparam int unsigned ADDR_WIDTH = SONG_WIDTH + IDX_WIDTH;

  localparam logic [IDX_WIDTH-1:0] IDX_LAST = '1;
  localparam logic [IDX_WIDTH:0]   SKIP_EXT = (IDX_WIDTH+1)'(SKIP);
  localparam logic [IDX_WIDTH-1:0] SKIP_IDX = IDX_WIDTH'(SKIP);
  localparam logic [DUR_WIDTH-1:0] END_DUR  = DUR_WIDTH'(END_OF_SONG_DUR);

  state_e                state_q, state_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [NOTE_WIDTH-1:0] note_q, note_d;
  logic [DUR_WIDTH-1:0]  dur_q, dur_d;
  logic                  new_note_q, new_note_d;
  logic                  song_done_q, song_done_d;

  logic [WORD_WIDTH-1:0] rom_data;
  logic [NOTE_WIDTH-1:0] rom_note;
  logic [DUR_WIDTH-1:0]  rom_dur;
  logic [IDX_WIDTH:0]    ff_sum;

  // The ROM samples {song, idx} every cycle; the word captured on the FETCH
  // edge is the one ISSUE acts on, so a song change lands at the next FETCH.
  song_rom #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (WORD_WIDTH),
    .INIT       (ROM_INIT)
  ) u_rom (
    .clk    (clk),
    .addr_i ({song, idx_q}),
    .data_o (rom_data)
  );

  assign {rom_note, rom_dur} = rom_data;

  // One extra bit so a skip past the last note shows up as a carry.
  assign ff_sum = {1'b0, idx_q} + SKIP_EXT;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    note_d      = note_q;
    dur_d       = dur_q;
    new_note_d  = 1'b0;
    // Reported for any cycle spent in END, even when a higher-priority
    // command redirects the FSM in that same cycle.
    song_done_d = (state_q == END);

    if (reset_player) begin
      state_d = IDLE;
      idx_d   = '0;
    end else if (rewind) begin
      idx_d   = ({1'b0, idx_q} >= SKIP_EXT) ? (idx_q - SKIP_IDX) : '0;
      state_d = IDLE;
    end else if (ff) begin
      if (ff_sum[IDX_WIDTH]) begin
        state_d = END;
      end else begin
        idx_d   = ff_sum[IDX_WIDTH-1:0];
        state_d = IDLE;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (play) state_d = FETCH;
        end
        FETCH: begin
          state_d = ISSUE;
        end
        ISSUE: begin
          if (rom_dur == END_DUR) begin
            state_d = END;
          end else begin
            note_d     = rom_note;
            dur_d      = rom_dur;
            new_note_d = 1'b1;
            state_d    = WAIT;
          end
        end
        WAIT: begin
          // Dropping play here does not leave WAIT; the player pauses itself.
          if (note_done) begin
            if (idx_q == IDX_LAST) begin
              state_d = END;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = play ? FETCH : IDLE;
            end
          end
        end
        END: begin
          idx_d   = '0;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      note_q      <= '0;
      dur_q       <= '0;
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      note_q      <= note_d;
      dur_q       <= dur_d;
      new_note_q  <= new_note_d;
      song_done_q <= song_done_d;
    end
  end

  assign new_note  = new_note_q;
  assign note      = note_q;
  assign duration  = dur_q;
  assign song_done = song_done_q;

endmodule

// File: tb/tb_song_reader.sv
// tb/tb_song_reader.sv - self-checking bench for song_reader
module tb_song_reader;

  localparam int IW     = 5;
  localparam int NW     = 6;
  localparam int DW     = 6;
  localparam int SK     = 4;
  localparam int WW     = NW + DW;
  localparam int NWORDS = 4 * (2**IW);
  localparam int LAST   = (2**IW) - 1;

  // Song 0: note i+32, dur i+1 (no marker). Song 1: {10,5},{12,3},marker.
  // Song 2: note 63-i, dur (i%7)+1 (no marker). Song 3: marker at note 0.
  function automatic logic [WW-1:0] rom_word(input int s, input int i);
    logic [NW-1:0] n;
    logic [DW-1:0] d;
    n = '0;
    d = '0;
    case (s)
      0: begin n = NW'(i + 32); d = DW'(i + 1); end
      1: begin
        if (i == 0) begin n = 6'd10; d = 6'd5; end
        else if (i == 1) begin n = 6'd12; d = 6'd3; end
      end
      2: begin n = NW'(63 - i); d = DW'((i % 7) + 1); end
      default: begin n = '0; d = '0; end
    endcase
    return {n, d};
  endfunction

  function automatic logic [NWORDS*WW-1:0] build_rom();
    logic [NWORDS*WW-1:0] r;
    r = '0;
    for (int a = 0; a < NWORDS; a++) r[a*WW +: WW] = rom_word(a / (2**IW), a % (2**IW));
    return r;
  endfunction

  localparam logic [NWORDS*WW-1:0] ROM_IMG = build_rom();

  logic          clk;
  logic          reset, play, rewind, ff, reset_player, note_done;
  logic [1:0]    song;
  logic          new_note, song_done;
  logic [NW-1:0] note;
  logic [DW-1:0] duration;

  int n_cmp = 0;
  int n_bad = 0;

  song_reader #(
    .IDX_WIDTH  (IW),
    .NOTE_WIDTH (NW),
    .DUR_WIDTH  (DW),
    .SKIP       (SK),
    .ROM_INIT   (ROM_IMG)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .play         (play),
    .rewind       (rewind),
    .ff           (ff),
    .reset_player (reset_player),
    .song         (song),
    .note_done    (note_done),
    .new_note     (new_note),
    .note         (note),
    .duration     (duration),
    .song_done    (song_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the note index and time-to-issue with plain counters; a note is
  // issued three edges after a fetch is launched from idle or note_done.
  int            m_idx = 0;
  int            m_left = 0;
  int            m_song = 0;
  bit            m_wait = 0;
  bit            m_end = 0;
  bit            model_on = 0;
  logic          exp_nn = 0;
  logic          exp_sd = 0;
  logic [NW-1:0] exp_note = '0;
  logic [DW-1:0] exp_dur = '0;

  always @(posedge clk) begin
    logic [WW-1:0] w;
    exp_nn = 1'b0;
    exp_sd = m_end;
    if (reset) begin
      model_on = 1;
      exp_sd = 1'b0;
      exp_note = '0;
      exp_dur = '0;
      m_idx = 0; m_left = 0; m_wait = 0; m_end = 0;
    end else if (reset_player) begin
      m_idx = 0; m_left = 0; m_wait = 0; m_end = 0;
    end else if (rewind) begin
      m_idx = (m_idx >= SK) ? m_idx - SK : 0;
      m_left = 0; m_wait = 0; m_end = 0;
    end else if (ff) begin
      m_left = 0; m_wait = 0;
      if (m_idx + SK > LAST) m_end = 1;
      else begin m_idx = m_idx + SK; m_end = 0; end
    end else if (m_end) begin
      m_idx = 0; m_end = 0;
    end else if (m_left > 0) begin
      if (m_left == 2) m_song = int'(song);
      m_left--;
      if (m_left == 0) begin
        w = rom_word(m_song, m_idx);
        if (w[DW-1:0] == 0) m_end = 1;
        else begin
          exp_note = w[WW-1:DW];
          exp_dur = w[DW-1:0];
          exp_nn = 1'b1;
          m_wait = 1;
        end
      end
    end else if (m_wait) begin
      if (note_done) begin
        m_wait = 0;
        if (m_idx == LAST) m_end = 1;
        else begin
          m_idx++;
          if (play) m_left = 2;
        end
      end
    end else if (play) begin
      m_left = 2;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("cyc_new_note", int'(new_note), int'(exp_nn));
      chk("cyc_song_done", int'(song_done), int'(exp_sd));
      chk("cyc_note", int'(note), int'(exp_note));
      chk("cyc_duration", int'(duration), int'(exp_dur));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_nd();
    note_done = 1'b1; tick(); note_done = 1'b0;
  endtask

  task automatic pulse_rp();
    reset_player = 1'b1; tick(); reset_player = 1'b0;
  endtask

  task automatic pulse_rw();
    rewind = 1'b1; tick(); rewind = 1'b0;
  endtask

  task automatic pulse_ff();
    ff = 1'b1; tick(); ff = 1'b0;
  endtask

  task automatic wait_nn(input string name, input int max_cyc);
    bit seen;
    seen = 0;
    for (int c = 0; c < max_cyc && !seen; c++) begin
      tick();
      if (new_note) seen = 1;
    end
    chk(name, int'(seen), 1);
  endtask

  task automatic wait_sd(input string name, input int max_cyc);
    bit seen;
    seen = 0;
    for (int c = 0; c < max_cyc && !seen; c++) begin
      tick();
      if (song_done) seen = 1;
    end
    chk(name, int'(seen), 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int quiet;
    reset = 1'b1; play = 1'b0; rewind = 1'b0; ff = 1'b0;
    reset_player = 1'b0; note_done = 1'b0; song = 2'd0;
    tick(); tick();
    chk("rst_new_note", int'(new_note), 0);
    chk("rst_note", int'(note), 0);
    chk("rst_duration", int'(duration), 0);
    chk("rst_song_done", int'(song_done), 0);
    reset = 1'b0;
    tick();

    // Song 1: two notes then the marker, note_done two cycles after new_note.
    song = 2'd1; play = 1'b1;
    wait_nn("t1_wait0", 10);
    chk("t1_note0", int'(note), 10);
    chk("t1_dur0", int'(duration), 5);
    tick(); pulse_nd();
    wait_nn("t1_wait1", 10);
    chk("t1_note1", int'(note), 12);
    chk("t1_dur1", int'(duration), 3);
    tick(); pulse_nd();
    wait_sd("t1_song_done", 10);
    pulse_rp();
    wait_nn("t1_restart", 10);
    chk("t1_restart_note", int'(note), 10);
    play = 1'b0;
    pulse_rp();

    // Song 2: all 32 notes, no marker.
    song = 2'd2; play = 1'b1;
    for (int k = 0; k < 32; k++) begin
      wait_nn("t2_note_wait", 10);
      tick(); pulse_nd();
    end
    chk("t2_last_note", int'(note), 32);
    chk("t2_last_dur", int'(duration), 4);
    wait_sd("t2_song_done", 5);
    reset_player = 1'b1; play = 1'b0;
    tick();
    reset_player = 1'b0;
    play = 1'b1;
    wait_nn("t2_wrap", 10);
    chk("t2_wrap_note", int'(note), 63);
    play = 1'b0;
    pulse_rp();

    // Rewind: idx 2 saturates to 0, idx 9 goes to 5.
    song = 2'd0; play = 1'b1;
    wait_nn("t3_n0", 10);
    tick(); pulse_nd();
    wait_nn("t3_n1", 10);
    tick(); pulse_nd();
    pulse_rw();
    wait_nn("t3_after_rw0", 10);
    chk("t3_sat_note", int'(note), 32);
    chk("t3_sat_dur", int'(duration), 1);
    for (int k = 0; k < 9; k++) begin
      tick(); pulse_nd();
      wait_nn("t3_adv", 10);
    end
    chk("t3_idx9_note", int'(note), 41);
    pulse_rw();
    wait_nn("t3_after_rw9", 10);
    chk("t3_idx5_note", int'(note), 37);
    chk("t3_idx5_dur", int'(duration), 6);

    // ff: 0 -> 20 -> 24, then 28 -> 29 -> past end.
    play = 1'b0;
    pulse_rp();
    for (int k = 0; k < 5; k++) pulse_ff();
    pulse_ff();
    play = 1'b1;
    wait_nn("t4_idx24", 10);
    chk("t4_idx24_note", int'(note), 56);
    chk("t4_idx24_dur", int'(duration), 25);
    pulse_ff();
    wait_nn("t4_idx28", 10);
    chk("t4_idx28_note", int'(note), 60);
    tick(); pulse_nd();
    play = 1'b0;
    pulse_ff();
    reset_player = 1'b1;
    tick();
    reset_player = 1'b0;
    chk("t4_ff_song_done", int'(song_done), 1);
    chk("t4_ff_no_note", int'(new_note), 0);
    repeat (4) tick();

    // play dropped during WAIT.
    play = 1'b1;
    wait_nn("t5_n0", 10);
    chk("t5_n0_note", int'(note), 32);
    play = 1'b0;
    tick(); pulse_nd();
    quiet = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      quiet += int'(new_note);
    end
    chk("t5_quiet", quiet, 0);
    play = 1'b1;
    tick(); tick(); tick();
    chk("t5_latency", int'(new_note), 1);
    chk("t5_next_note", int'(note), 33);
    chk("t5_next_dur", int'(duration), 2);

    // reset_player in WAIT, reset in ISSUE, late note_done ignored.
    pulse_rp();
    wait_nn("t6_after_rp", 10);
    chk("t6_rp_note", int'(note), 32);
    play = 1'b0;
    pulse_rp();
    play = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("t6_rst_new_note", int'(new_note), 0);
    chk("t6_rst_note", int'(note), 0);
    chk("t6_rst_dur", int'(duration), 0);
    chk("t6_rst_song_done", int'(song_done), 0);
    reset = 1'b0; play = 1'b0;
    pulse_nd();
    quiet = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      quiet += int'(new_note);
    end
    chk("t6_late_nd_quiet", quiet, 0);
    play = 1'b1;
    wait_nn("t6_restart", 10);
    chk("t6_restart_note", int'(note), 32);
    play = 1'b0;
    pulse_rp();

    // Song 3: marker at the first word.
    song = 2'd3; play = 1'b1;
    wait_sd("t7_song_done", 10);
    play = 1'b0;
    pulse_rp();
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
